// File: rtl/duty_cycle_pwm.sv
// duty_cycle_pwm: 16-phase PWM generator with a prescaled phase clock and a
// double-buffered duty value.
//
// Optional feature macro: PWM_COMPLEMENT_EN adds the complementary output
// pwm_n with dead-time insertion. Without it, pwm_out is the raw waveform.
//
// Parameters:
//   PRESCALE - clk cycles per phase step (1..65535)
//   DEADTIME - dead-time length in clk cycles (1..15), complement build only
// Ports:
//   clk          - clock, rising edge
//   reset        - asynchronous, active-high reset
//   enable       - level request to run the generator
//   duty_sel     - requested duty in sixteenths of a period (0..15)
//   pwm_out      - registered PWM waveform
//   period_start - one-cycle pulse on phase 0 of every period
//   duty_active  - duty value applied to the current period
//   pwm_n        - complementary output (PWM_COMPLEMENT_EN only)
//   busy         - high whenever the generator is not idle
module duty_cycle_pwm #(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned DEADTIME = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] duty_sel,
  output logic       pwm_out,
  output logic       period_start,
  output logic [3:0] duty_active,
`ifdef PWM_COMPLEMENT_EN
  output logic       pwm_n,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  localparam int unsigned PresWidth = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PresWidth-1:0] PresMax = PresWidth'(PRESCALE - 1);

  state_e               state_q, state_d;
  logic [PresWidth-1:0] presc_q, presc_d;
  logic [3:0]           phase_q, phase_d;
  logic [3:0]           duty_q, duty_d;
  logic                 start_q, start_d;
  logic                 out_q, out_d;
  logic                 raw_d;
  logic                 tick;
  logic                 wrap;

  assign tick = (state_q != StIdle) && (presc_q == PresMax);
  assign wrap = tick && (phase_q == 4'd15);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    phase_d = phase_q;
    duty_d  = duty_q;
    start_d = 1'b0;

    // Counters free-run whenever the generator is active; STOP<->RUN never restarts them.
    if (state_q != StIdle) begin
      if (tick) begin
        presc_d = '0;
        phase_d = phase_q + 4'd1;
      end else begin
        presc_d = presc_q + PresWidth'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StRun;
          presc_d = '0;
          phase_d = '0;
          duty_d  = duty_sel;
          start_d = 1'b1;
        end
      end
      StRun: begin
        if (!enable) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (enable) begin
          state_d = StRun;
        end else if (wrap) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Period boundary: duty_sel is only sampled here, so mid-period changes cannot glitch.
    if (wrap && (state_d != StIdle)) begin
      duty_d  = duty_sel;
      start_d = 1'b1;
    end

    // Built from next-state values so the registered output lines up with the phase.
    raw_d = (state_d != StIdle) && (phase_d < duty_d);
  end

`ifdef PWM_COMPLEMENT_EN
  localparam logic [4:0] CntSat = 5'(DEADTIME + 1);
  localparam logic [4:0] DeadLen = 5'(DEADTIME);

  logic [4:0] hi_cnt_q, hi_cnt_d;
  logic [4:0] lo_cnt_q, lo_cnt_d;
  logic       pwm_n_q, pwm_n_d;

  // Run-length counters of the raw waveform, saturating just past the dead time.
  always_comb begin
    hi_cnt_d = '0;
    lo_cnt_d = '0;
    if (raw_d) begin
      hi_cnt_d = (hi_cnt_q == CntSat) ? CntSat : hi_cnt_q + 5'd1;
    end else begin
      lo_cnt_d = (lo_cnt_q == CntSat) ? CntSat : lo_cnt_q + 5'd1;
    end
    // Only one counter is nonzero at a time, so the outputs can never overlap.
    out_d   = hi_cnt_d > DeadLen;
    pwm_n_d = (lo_cnt_d > DeadLen) && (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_cnt_q <= '0;
      lo_cnt_q <= '0;
      pwm_n_q  <= 1'b0;
    end else begin
      hi_cnt_q <= hi_cnt_d;
      lo_cnt_q <= lo_cnt_d;
      pwm_n_q  <= pwm_n_d;
    end
  end

  assign pwm_n = pwm_n_q;
`else
  always_comb begin
    out_d = raw_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      presc_q <= '0;
      phase_q <= '0;
      duty_q  <= '0;
      start_q <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
      duty_q  <= duty_d;
      start_q <= start_d;
      out_q   <= out_d;
    end
  end

  assign pwm_out      = out_q;
  assign period_start = start_q;
  assign duty_active  = duty_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: doc/duty_cycle_pwm.md
DUTY_CYCLE_PWM -- requirements
Module: duty_cycle_pwm

Interface
REQ-001 Parameter PRESCALE, default 1, SHALL set the number of clk cycles per phase step (legal range 1..65535).
REQ-002 Parameter DEADTIME, default 2, SHALL set the dead-time length in clk cycles (legal range 1..15); it is used only when PWM_COMPLEMENT_EN is defined.
REQ-003 clk  input  1  SHALL be the clock; all state updates on the rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 enable  input  1  SHALL be a level request to run the generator.
REQ-006 duty_sel  input  4  SHALL be the requested duty value, 0..15, in sixteenths of a period.
REQ-007 pwm_out  output  1  SHALL be the registered PWM waveform.
REQ-008 period_start  output  1  SHALL be a one-cycle pulse marking phase 0 of each period.
REQ-009 duty_active  output  4  SHALL be the duty value applied to the current period.
REQ-010 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-011 pwm_n  output  1  SHALL be the complementary output, present only when PWM_COMPLEMENT_EN is defined.

Function
REQ-012 Prescaler SHALL count 0..PRESCALE-1 while not IDLE and issue a tick on the cycle it holds PRESCALE-1, then wrap to 0; PRESCALE=1 means a tick every cycle.
REQ-013 Phase counter (4 bits) SHALL advance by 1 on each tick while not IDLE, wrapping 15->0.
REQ-014 States SHALL be IDLE, RUN and STOP, with the following transitions:
  - IDLE->RUN on enable=1;
  - RUN->STOP on enable=0;
  - STOP->RUN on enable=1, without a phase or prescaler restart;
  - STOP->IDLE on a tick with phase=15.
REQ-015 On IDLE->RUN the generator SHALL set phase=0 and prescaler=0, load duty_active<=duty_sel, and pulse period_start in the following cycle.
REQ-016 On a tick with phase=15 in RUN, the generator SHALL wrap phase to 0, load duty_active<=duty_sel, and assert period_start for exactly one cycle.
REQ-017 duty_sel changes mid-period SHALL have no effect until the next period boundary (double-buffered, glitch-free).
REQ-018 Raw waveform SHALL be registered high iff (next state != IDLE) and (next phase < next duty_active), computed from next-state values so that pwm_out shows no extra cycle of latency relative to the phase.
REQ-019 Duty 0 SHALL give a constant-low output; duty 15 SHALL give high for phases 0..14 and low for phase 15; no 100% duty exists.
REQ-020 In STOP the current period SHALL complete normally; on entry to IDLE pwm_out SHALL be 0 and duty_active SHALL hold its last value.
REQ-021 When enable falls and rises in the same period, the waveform SHALL be uninterrupted.

Reset
REQ-022 Reset SHALL force IDLE, phase=0, prescaler=0, duty_active=0, pwm_out=0, period_start=0, busy=0, pwm_n=0 and dead-time counters=0, immediately and regardless of clk.
REQ-023 Reset asserted mid-period SHALL abort the period; after release the block waits in IDLE for enable.

Configuration
REQ-024 Macro PWM_COMPLEMENT_EN SHALL add the pwm_n port and dead-time insertion when defined.
  - pwm_out SHALL be high iff raw has been high for more than DEADTIME consecutive cycles.
  - pwm_n SHALL be high iff raw has been low for more than DEADTIME consecutive cycles and state != IDLE.
  - pwm_out and pwm_n SHALL never be high together.
REQ-025 Without PWM_COMPLEMENT_EN, pwm_n SHALL be absent and pwm_out SHALL equal raw.

Verification
REQ-026 PRESCALE=1, enable=1, duty_sel=4 -> pwm_out high 4 cycles, low 12 cycles; period_start every 16 cycles.
REQ-027 duty_sel=0 -> pwm_out constant 0; duty_sel=15 -> 15 cycles high, 1 cycle low, repeating.
REQ-028 duty_sel changes 4->10 at phase 7 -> current period keeps 4 high cycles; next period has 10 high cycles; duty_active changes on the period_start cycle.
REQ-029 enable drops at phase 5 -> period completes through phase 15, then busy=0 and pwm_out=0; re-enable at phase 9 instead -> period continues seamlessly.
REQ-030 PRESCALE=3, duty_sel=2 -> pwm_out high 6 cycles per 48-cycle period; reset at cycle 20 -> all outputs 0 in the same cycle.
REQ-031 PWM_COMPLEMENT_EN, DEADTIME=2, duty_sel=8 -> pwm_out high 6 cycles, pwm_n high 6 cycles, and 2-cycle both-low gaps at each edge.
